oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- OAM DMA controller and CPU bus arbiter, sitting between sm83 and the memory map in dmg_main.
- A CPU write to FF46 copies 160 bytes from {src,8'h00}..{src,8'h9F} into OAM FE00–FE9F at one byte per M-cycle.
- While a transfer runs, DMA owns the external bus (ROM/VRAM/WRAM) and the CPU is restricted to FF00–FFFF.
- Also provides the CPU read-data mux for the OAM, IO and external regions.

Parameters:
- OAM_LEN, 160, bytes per transfer (index width is 8 bits; OAM_LEN ≤ 256).
- REG_ADDR, 16'hFF46, DMA source register address.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  M-cycle enable; one clk pulse per M-cycle.
- cpu_addr  in  16  CPU address.
- cpu_d_out  in  8  CPU write data.
- cpu_write  in  1  CPU write strobe (level for the whole M-cycle).
- cpu_d_in  out  8  read data returned to the CPU.
- bus_addr  out  16  address to the external region (ROM/VRAM/WRAM decode).
- bus_write  out  1  external write strobe.
- bus_d_rd  in  8  external read data; combinational, valid by the ce edge.
- io_d_rd  in  8  read data for FF00–FFFF, already muxed by the top level; excludes FF46.
- oam_addr  out  8  OAM address.
- oam_write  out  1  OAM write strobe.
- oam_d_wr  out  8  OAM write data.
- oam_d_rd  in  8  OAM read data.
- dma_active  out  1  high while in XFER.

Behaviour:
- All state updates occur on posedge clk qualified by ce, except reset, which acts on any posedge clk.
- States: IDLE, START, XFER. Registers: src[7:0], idx[7:0].
- Reset values: state = IDLE, src = 8'h00, idx = 0, dma_active = 0.
  - Combinational outputs then follow the CPU pass-through rules: oam_write = 0 unless the CPU targets OAM; bus_write = cpu_write for addresses below FE00.
- Trigger: ce && cpu_write && cpu_addr == REG_ADDR, accepted in any state.
  - Sets src = cpu_d_out, idx = 0, state = START.
- START: lasts exactly one M-cycle. CPU is not blocked. Next ce → XFER.
- XFER, DMA address: bus_addr = {eff_src, idx}, where eff_src = src & 8'hDF if src[7:5] == 3'b111 (echo-RAM fold), otherwise src.
- XFER, OAM write: oam_addr = idx, oam_d_wr = bus_d_rd, oam_write = 1, bus_write = 0.
- XFER, ce edge: idx += 1. At idx == OAM_LEN-1, go to IDLE and set idx = 0.
  - dma_active is high for exactly OAM_LEN M-cycles, beginning one M-cycle after the trigger M-cycle.
- Restart: a trigger during START or XFER restarts the transfer.
  - New src, idx = 0, state = START.
  - The byte at the current idx is still written on that edge; no further old-source bytes are written.
- CPU pass-through (IDLE/START):
  - bus_addr = cpu_addr.
  - bus_write = cpu_write && cpu_addr < 16'hFE00.
  - oam_addr = cpu_addr[7:0].
  - oam_write = cpu_write && cpu_addr in FE00–FE9F.
  - oam_d_wr = cpu_d_out.
- CPU blocking (XFER):
  - CPU writes below FF00 are dropped.
  - CPU reads below FF00 return 8'hFF.
  - FF00–FFFF accesses are unaffected; this includes writing FF46, which restarts the transfer.
- cpu_d_in mux, in priority order:
  1. cpu_addr == REG_ADDR → src (readback).
  2. cpu_addr ≥ FF00 → io_d_rd.
  3. dma_active → 8'hFF.
  4. FE00–FE9F → oam_d_rd.
  5. FEA0–FEFF → 8'h00.
  6. Otherwise → bus_d_rd.
- ce low: no state change. Outputs remain combinational from the current state and the inputs.
- Reset mid-transfer: returns to IDLE on the next clk. No further oam_write is issued; OAM contents are left partial.

Test Plan:
- Reset, then write FF46 = 8'hC1 → dma_active rises one M-cycle after the write and stays high 160 M-cycles. oam_write pulses with oam_addr 0..159 and bus_addr C100..C19F. OAM[i] equals the source model byte C1xx.
- During XFER, CPU reads C000 → cpu_d_in = 8'hFF, bus_addr still shows the DMA address. CPU write to 8000 → bus_write = 0.
- During XFER, CPU reads FF80 → cpu_d_in = io_d_rd. CPU reads FF46 → cpu_d_in = 8'hC1.
- Write FF46 = 8'hF0 → bus_addr sequence D000..D09F (echo fold).
- Write FF46 = 8'hC1; at idx 50 write FF46 = 8'hC2 → byte 50 from C132 is written. After the one START M-cycle, the transfer restarts at C200 and runs 160 more M-cycles.
- Assert rst at idx 80 → state IDLE, dma_active = 0, no oam_write on subsequent cycles. CPU write to FE10 afterwards → oam_write = 1, oam_addr = 8'h10.

Source files
------------

// File: rtl/oam_dma_ctrl_if.sv
// Signal bundle between the CPU/memory map and the OAM DMA controller.
// slave = controller side, master = surrounding top level (or bench).
interface oam_dma_ctrl_if;
   // Strobe semantics: every strobe and address is sampled only on a clk edge
   // with ce high; all read data is combinational and valid by that edge.
   logic        ce;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_d_out;
   logic        cpu_write;
   logic [7:0]  cpu_d_in;
   logic [15:0] bus_addr;
   logic        bus_write;
   logic [7:0]  bus_d_rd;
   logic [7:0]  io_d_rd;
   logic [7:0]  oam_addr;
   logic        oam_write;
   logic [7:0]  oam_d_wr;
   logic [7:0]  oam_d_rd;
   logic        dma_active;
   logic [1:0]  state_dbg;

   modport slave (
      input  ce, cpu_addr, cpu_d_out, cpu_write, bus_d_rd, io_d_rd, oam_d_rd,
      output cpu_d_in, bus_addr, bus_write, oam_addr, oam_write, oam_d_wr,
             dma_active, state_dbg
   );

   modport master (
      output ce, cpu_addr, cpu_d_out, cpu_write, bus_d_rd, io_d_rd, oam_d_rd,
      input  cpu_d_in, bus_addr, bus_write, oam_addr, oam_write, oam_d_wr,
             dma_active, state_dbg
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine and CPU bus arbiter: copies OAM_LEN bytes into OAM on an
// FF46 write and fences the CPU off the external bus while the copy runs.
module oam_dma_ctrl #(
   parameter int          OAM_LEN  = 160,
   parameter logic [15:0] REG_ADDR = 16'hFF46
) (
   input logic           clk,
   input logic           rst,
   oam_dma_ctrl_if.slave bif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

   state_t     state, state_nx;
   logic [7:0] src, src_nx;
   logic [7:0] idx, idx_nx;
   logic       trig;
   logic       in_xfer;
   logic       oam_hit;
   logic       oam_gap;
   logic [7:0] eff_src;

   assign trig    = bif.ce && bif.cpu_write && (bif.cpu_addr == REG_ADDR);
   assign in_xfer = (state == XFER);
   assign oam_hit = (bif.cpu_addr >= 16'hFE00) && (bif.cpu_addr <= 16'hFE9F);
   assign oam_gap = (bif.cpu_addr >= 16'hFEA0) && (bif.cpu_addr <= 16'hFEFF);
   // Sources in E000-FFFF fold down onto WRAM, as the echo region does.
   assign eff_src = (src[7:5] == 3'b111) ? (src & 8'hDF) : src;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         src   <= 8'h00;
         idx   <= 8'h00;
      end else if (bif.ce) begin
         state <= state_nx;
         src   <= src_nx;
         idx   <= idx_nx;
      end
   end

   // A trigger wins over sequencing in every state, so a rewrite of the
   // register restarts the copy from byte zero.
   always_comb begin
      state_nx = state;
      src_nx   = src;
      idx_nx   = idx;
      if (trig) begin
         src_nx   = bif.cpu_d_out;
         idx_nx   = 8'h00;
         state_nx = START;
      end else begin
         case (state)
            START: state_nx = XFER;
            XFER: begin
               if (idx == LAST_IDX) begin
                  idx_nx   = 8'h00;
                  state_nx = IDLE;
               end else begin
                  idx_nx = idx + 8'h01;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      bif.bus_addr  = bif.cpu_addr;
      bif.bus_write = bif.cpu_write && (bif.cpu_addr < 16'hFE00);
      bif.oam_addr  = bif.cpu_addr[7:0];
      bif.oam_write = bif.cpu_write && oam_hit;
      bif.oam_d_wr  = bif.cpu_d_out;
      if (in_xfer) begin
         bif.bus_addr  = {eff_src, idx};
         bif.bus_write = 1'b0;
         bif.oam_addr  = idx;
         bif.oam_write = 1'b1;
         bif.oam_d_wr  = bif.bus_d_rd;
      end
   end

   always_comb begin
      if (bif.cpu_addr == REG_ADDR)
         bif.cpu_d_in = src;
      else if (bif.cpu_addr >= 16'hFF00)
         bif.cpu_d_in = bif.io_d_rd;
      else if (in_xfer)
         bif.cpu_d_in = 8'hFF;
      else if (oam_hit)
         bif.cpu_d_in = bif.oam_d_rd;
      else if (oam_gap)
         bif.cpu_d_in = 8'h00;
      else
         bif.cpu_d_in = bif.bus_d_rd;
   end

   assign bif.dma_active = in_xfer;
   assign bif.state_dbg  = state;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: full copies, echo fold, CPU fencing,
// restart mid-copy and reset mid-copy, against a hashed source memory model.
module tb_oam_dma_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;
   logic [7:0]  salt = 8'h00;
   logic [7:0]  oam_mem [0:255];
   int          wr_cnt = 0;
   int          snap;

   oam_dma_ctrl_if bif ();

   oam_dma_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bif (bif.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] src_byte(input logic [15:0] a, input logic [7:0] s);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ s;
   endfunction

   assign bif.bus_d_rd = src_byte(bif.bus_addr, salt);
   assign bif.io_d_rd  = 8'h3C;
   assign bif.oam_d_rd = 8'hA7;

   always @(posedge clk) begin
      if (!rst && bif.ce && bif.oam_write) begin
         oam_mem[bif.oam_addr] <= bif.oam_d_wr;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One M-cycle: a ce-low edge (must not move state) then a ce-high edge.
   task automatic mc();
      bif.ce = 1'b0;
      @(posedge clk);
      #1;
      bif.ce = 1'b1;
      @(posedge clk);
      #1;
      bif.ce = 1'b0;
   endtask

   task automatic cpu_idle();
      bif.cpu_addr  = 16'h0000;
      bif.cpu_write = 1'b0;
      bif.cpu_d_out = 8'h00;
   endtask

   task automatic trigger(input logic [7:0] s);
      bif.cpu_addr  = 16'hFF46;
      bif.cpu_write = 1'b1;
      bif.cpu_d_out = s;
      mc();
      cpu_idle();
   endtask

   initial begin
      bif.ce = 1'b0;
      cpu_idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_state", 16'(bif.state_dbg), 16'd0);
      chk("rst_active", 16'(bif.dma_active), 16'd0);
      chk("rst_oam_wr", 16'(bif.oam_write), 16'd0);
      chk("rst_bus_wr", 16'(bif.bus_write), 16'd0);
      bif.cpu_addr = 16'hFF46;
      #1 chk("rst_src", 16'(bif.cpu_d_in), 16'h0000);

      // Pass-through while idle
      bif.cpu_addr = 16'h8000; bif.cpu_write = 1'b1;
      #1 chk("pt_bus_wr", 16'(bif.bus_write), 16'd1);
      chk("pt_bus_addr", bif.bus_addr, 16'h8000);
      bif.cpu_addr = 16'hFE05;
      #1 chk("pt_oam_wr", 16'(bif.oam_write), 16'd1);
      chk("pt_oam_addr", 16'(bif.oam_addr), 16'h0005);
      chk("pt_bus_wr_fe", 16'(bif.bus_write), 16'd0);
      bif.cpu_write = 1'b0;
      bif.cpu_addr = 16'hFE10;
      #1 chk("pt_rd_oam", 16'(bif.cpu_d_in), 16'h00A7);
      bif.cpu_addr = 16'hFEA0;
      #1 chk("pt_rd_gap", 16'(bif.cpu_d_in), 16'h0000);
      bif.cpu_addr = 16'hC005;
      #1 chk("pt_rd_bus", 16'(bif.cpu_d_in), 16'(src_byte(16'hC005, salt)));
      cpu_idle();

      // Full copy from C100
      salt = 8'h11;
      trigger(8'hC1);
      chk("c1_start_state", 16'(bif.state_dbg), 16'd1);
      chk("c1_start_active", 16'(bif.dma_active), 16'd0);
      mc();
      for (int i = 0; i < 160; i++) begin
         chk("c1_active", 16'(bif.dma_active), 16'd1);
         chk("c1_oam_wr", 16'(bif.oam_write), 16'd1);
         chk("c1_oam_addr", 16'(bif.oam_addr), 16'(i));
         chk("c1_bus_addr", bif.bus_addr, {8'hC1, 8'(i)});
         chk("c1_oam_data", 16'(bif.oam_d_wr), 16'(src_byte({8'hC1, 8'(i)}, salt)));
         if (i == 10) begin
            bif.cpu_addr = 16'hC000;
            #1 chk("blk_rd_ff", 16'(bif.cpu_d_in), 16'h00FF);
            chk("blk_bus_addr", bif.bus_addr, 16'hC10A);
            bif.cpu_addr = 16'h8000; bif.cpu_write = 1'b1;
            #1 chk("blk_bus_wr", 16'(bif.bus_write), 16'd0);
            bif.cpu_write = 1'b0;
            bif.cpu_addr = 16'hFF80;
            #1 chk("blk_rd_io", 16'(bif.cpu_d_in), 16'h003C);
            bif.cpu_addr = 16'hFF46;
            #1 chk("blk_rd_src", 16'(bif.cpu_d_in), 16'h00C1);
            cpu_idle();
         end
         if (i == 20) begin
            @(posedge clk);
            #1 chk("ce_low_hold", 16'(bif.oam_addr), 16'd20);
         end
         mc();
      end
      chk("c1_end_active", 16'(bif.dma_active), 16'd0);
      chk("c1_end_state", 16'(bif.state_dbg), 16'd0);
      chk("c1_end_oam_wr", 16'(bif.oam_write), 16'd0);
      chk("c1_mem0", 16'(oam_mem[0]), 16'(src_byte(16'hC100, salt)));
      chk("c1_mem80", 16'(oam_mem[80]), 16'(src_byte(16'hC150, salt)));
      chk("c1_mem159", 16'(oam_mem[159]), 16'(src_byte(16'hC19F, salt)));

      // Echo fold: F0 reads from D000
      salt = 8'h22;
      trigger(8'hF0);
      mc();
      for (int i = 0; i < 160; i++) begin
         chk("echo_bus_addr", bif.bus_addr, {8'hD0, 8'(i)});
         mc();
      end
      chk("echo_end_active", 16'(bif.dma_active), 16'd0);
      chk("echo_mem7", 16'(oam_mem[7]), 16'(src_byte(16'hD007, salt)));

      // Restart at idx 50
      salt = 8'h33;
      trigger(8'hC1);
      mc();
      repeat (50) mc();
      chk("rs_oam_addr", 16'(bif.oam_addr), 16'd50);
      chk("rs_bus_addr", bif.bus_addr, 16'hC132);
      snap = wr_cnt;
      salt = 8'h44;
      trigger(8'hC2);
      chk("rs_byte50", 16'(oam_mem[50]), 16'(src_byte(16'hC132, 8'h44)));
      chk("rs_start_state", 16'(bif.state_dbg), 16'd1);
      chk("rs_start_active", 16'(bif.dma_active), 16'd0);
      chk("rs_start_oam_wr", 16'(bif.oam_write), 16'd0);
      mc();
      for (int i = 0; i < 160; i++) begin
         chk("rs_active", 16'(bif.dma_active), 16'd1);
         chk("rs_bus_addr_seq", bif.bus_addr, {8'hC2, 8'(i)});
         mc();
      end
      chk("rs_end_active", 16'(bif.dma_active), 16'd0);
      chk("rs_wr_count", 16'(wr_cnt - snap), 16'd161);
      chk("rs_mem51", 16'(oam_mem[51]), 16'(src_byte(16'hC233, salt)));

      // Reset at idx 80
      salt = 8'h55;
      trigger(8'hC1);
      mc();
      repeat (80) mc();
      chk("rst80_oam_addr", 16'(bif.oam_addr), 16'd80);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst80_state", 16'(bif.state_dbg), 16'd0);
      chk("rst80_active", 16'(bif.dma_active), 16'd0);
      chk("rst80_oam_wr", 16'(bif.oam_write), 16'd0);
      snap = wr_cnt;
      repeat (5) mc();
      chk("rst80_no_wr", 16'(wr_cnt - snap), 16'd0);
      chk("rst80_still_idle", 16'(bif.dma_active), 16'd0);
      bif.cpu_addr = 16'hFF46;
      #1 chk("rst80_src", 16'(bif.cpu_d_in), 16'h0000);
      bif.cpu_addr = 16'hFE10; bif.cpu_write = 1'b1; bif.cpu_d_out = 8'h9A;
      #1 chk("rst80_cpu_oam_wr", 16'(bif.oam_write), 16'd1);
      chk("rst80_cpu_oam_addr", 16'(bif.oam_addr), 16'h0010);
      chk("rst80_cpu_oam_data", 16'(bif.oam_d_wr), 16'h009A);
      cpu_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
